// File: rtl/fifo_ctrl.sv
// fifo_ctrl: sequencing controller for the 16x5 synchronous-read FIFO memory.
// Owns the read/write pointers, level and full/empty, and steers the memory
// read address one cycle early so mem_rdata already holds the head word
// whenever rd_valid is high.
// Optional feature macro: FIFO_ERR_FLAGS_EN (sticky overflow flag err_ovf).
module fifo_ctrl #(
  parameter int unsigned ADDR = 4,
  parameter int unsigned DW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [DW-1:0]   wr_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [DW-1:0]   rd_data,
  output logic [ADDR:0]   level,
  output logic            err_ovf,
  input  logic            err_clr,
  output logic            mem_we,
  output logic [ADDR-1:0] mem_addr_wr,
  output logic [ADDR-1:0] mem_addr_rd,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int unsigned PW    = ADDR + 1;
  localparam int unsigned DEPTH = 1 << ADDR;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          rd_valid_q, rd_valid_d;
  logic          push, pop;

  // Level and full status come from registered pointers only.
  assign level    = wr_ptr_q - rd_ptr_q;
  assign wr_ready = (level != PW'(DEPTH));
  assign rd_valid = rd_valid_q;
  assign rd_data  = mem_rdata;

  // A flush cycle suppresses both the push and the pop of that cycle.
  assign push = wr_valid & wr_ready & ~flush;
  assign pop  = rd_valid_q & rd_ready & ~flush;

  assign mem_we      = push;
  assign mem_addr_wr = wr_ptr_q[ADDR-1:0];
  assign mem_wdata   = wr_data;
  assign mem_addr_rd = rd_ptr_d[ADDR-1:0];

  // Next pointers; the head becomes visible only once its write edge has passed,
  // so the comparison uses the registered write pointer.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_valid_d = 1'b0;
    if (flush) begin
      rd_ptr_d   = wr_ptr_q;
      rd_valid_d = 1'b0;
    end else begin
      wr_ptr_d   = wr_ptr_q + PW'(push);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      rd_valid_d = (wr_ptr_q != rd_ptr_d);
    end
  end

  // Pointer and head-valid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic err_ovf_q, err_ovf_d;

  // Sticky overflow: a new overflow wins over a same-cycle clear; flush clears.
  always_comb begin
    err_ovf_d = err_ovf_q;
    if (flush) begin
      err_ovf_d = 1'b0;
    end else if (wr_valid && !wr_ready) begin
      err_ovf_d = 1'b1;
    end else if (err_clr) begin
      err_ovf_d = 1'b0;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
    end
  end

  assign err_ovf = err_ovf_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign err_ovf        = 1'b0;
`endif

endmodule
